// File: rtl/mdr_pkg.sv
// Shared types for the MDR host-side command sequencer.
package mdr_pkg;

  localparam int unsigned MDR_DW = 16;

  typedef enum logic [1:0] {
    OP_MUL  = 2'd0,
    OP_DIV  = 2'd1,
    OP_SQRT = 2'd2,
    OP_RSVD = 2'd3
  } mdr_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_X,
    ST_LD_X,
    ST_WAIT_Y,
    ST_LD_Y,
    ST_WAIT_RDY,
    ST_RESP
  } mdr_state_e;

endpackage

// File: rtl/mdr_watchdog.sv
// Per-wait-state cycle counter; expire is high during the LIMIT-th cycle of a wait.
module mdr_watchdog #(
  parameter int unsigned LIMIT = 254
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = en && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/mdr_cmd_seq.sv
// Host-side sequencer: takes one (op, x, y) command, walks the MDR load
// protocol, and returns result/remainder/error/timeout on a response channel.
module mdr_cmd_seq
  import mdr_pkg::*;
#(
  parameter int unsigned DW      = MDR_DW,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [DW-1:0] cmd_x,
  input  logic [DW-1:0] cmd_y,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_result,
  output logic [DW-1:0] rsp_remainder,
  output logic          rsp_error,
  output logic          rsp_timeout,
  output logic          mdr_start,
  output logic          mdr_load,
  output logic [1:0]    mdr_op,
  output logic [DW-1:0] mdr_data,
  input  logic          mdr_error,
  input  logic          mdr_load_x,
  input  logic          mdr_load_y,
  input  logic          mdr_ready,
  input  logic [DW-1:0] mdr_result,
  input  logic [DW-1:0] mdr_reminder
);

  mdr_state_e    state, next_state;
  mdr_op_e       op_q;
  logic [DW-1:0] x_q, y_q;

  logic          cmd_fire, cmd_rsvd, in_wait, wd_expire;
  logic          cap_en, cap_err_n, cap_to_n;
  logic [DW-1:0] cap_res_n, cap_rem_n;
  logic          cap_err, cap_to;
  logic [DW-1:0] cap_res, cap_rem;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign cmd_rsvd = (mdr_op_e'(cmd_op) == OP_RSVD);
  assign in_wait  = (state == ST_WAIT_X) || (state == ST_WAIT_Y) || (state == ST_WAIT_RDY);

  // Response flags trail RESP entry by a cycle, so expire one cycle early.
  mdr_watchdog #(.LIMIT(TIMEOUT - 1)) u_wd (
    .clk    (clk),
    .rst    (rst),
    .clr    (!in_wait),
    .en     (in_wait),
    .expire (wd_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    cap_en     = 1'b0;
    cap_res_n  = '0;
    cap_rem_n  = '0;
    cap_err_n  = 1'b0;
    cap_to_n   = 1'b0;
    unique case (state)
      ST_IDLE: if (cmd_fire) next_state = ST_START;
      // Reserved op idles through START (no pulse) before rejecting.
      ST_START: begin
        if (op_q == OP_RSVD) begin
          next_state = ST_RESP;
          cap_en     = 1'b1;
          cap_err_n  = 1'b1;
        end else begin
          next_state = ST_WAIT_X;
        end
      end
      ST_WAIT_X, ST_WAIT_Y, ST_WAIT_RDY: begin
        if (mdr_error || ((state == ST_WAIT_RDY) && mdr_ready)) begin
          next_state = ST_RESP;
          cap_en     = 1'b1;
          cap_res_n  = mdr_result;
          cap_rem_n  = mdr_reminder;
          cap_err_n  = mdr_error;
        end else if ((state == ST_WAIT_X) && mdr_load_x) begin
          next_state = ST_LD_X;
        end else if ((state == ST_WAIT_Y) && mdr_load_y) begin
          next_state = ST_LD_Y;
        end else if (wd_expire) begin
          next_state = ST_RESP;
          cap_en     = 1'b1;
          cap_to_n   = 1'b1;
        end
      end
      ST_LD_X: next_state = (op_q == OP_SQRT) ? ST_WAIT_RDY : ST_WAIT_Y;
      ST_LD_Y: next_state = ST_WAIT_RDY;
      ST_RESP: if (rsp_valid && rsp_ready) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q          <= OP_MUL;
      x_q           <= '0;
      y_q           <= '0;
      cap_res       <= '0;
      cap_rem       <= '0;
      cap_err       <= 1'b0;
      cap_to        <= 1'b0;
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_result    <= '0;
      rsp_remainder <= '0;
      rsp_error     <= 1'b0;
      rsp_timeout   <= 1'b0;
      mdr_start     <= 1'b0;
      mdr_load      <= 1'b0;
      mdr_op        <= '0;
      mdr_data      <= '0;
    end else begin
      if (cmd_fire) begin
        op_q <= mdr_op_e'(cmd_op);
        x_q  <= cmd_x;
        y_q  <= cmd_y;
      end

      cmd_ready <= (next_state == ST_IDLE);
      mdr_start <= (state == ST_IDLE) && cmd_fire && !cmd_rsvd;
      mdr_load  <= (next_state == ST_LD_X) || (next_state == ST_LD_Y);

      if (next_state == ST_LD_X)      mdr_data <= x_q;
      else if (next_state == ST_LD_Y) mdr_data <= y_q;

      if (next_state == ST_IDLE)                          mdr_op <= '0;
      else if ((state == ST_IDLE) && cmd_fire && !cmd_rsvd) mdr_op <= cmd_op;

      if (cap_en) begin
        cap_res <= cap_res_n;
        cap_rem <= cap_rem_n;
        cap_err <= cap_err_n;
        cap_to  <= cap_to_n;
      end

      if (state == ST_RESP) begin
        if (!rsp_valid) begin
          rsp_valid     <= 1'b1;
          rsp_result    <= cap_res;
          rsp_remainder <= cap_rem;
          rsp_error     <= cap_err;
          rsp_timeout   <= cap_to;
        end else if (rsp_ready) begin
          rsp_valid     <= 1'b0;
          rsp_result    <= '0;
          rsp_remainder <= '0;
          rsp_error     <= 1'b0;
          rsp_timeout   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdr_cmd_seq.sv
// Scoreboard bench for mdr_cmd_seq with a registered, responsive MDR model.
module tb_mdr_cmd_seq;
  import mdr_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned TO = 255;

  logic          clk, rst;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [DW-1:0] cmd_x, cmd_y;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_result, rsp_remainder;
  logic          rsp_error, rsp_timeout;
  logic          mdr_start, mdr_load;
  logic [1:0]    mdr_op;
  logic [DW-1:0] mdr_data;
  logic          mdr_error, mdr_load_x, mdr_load_y, mdr_ready;
  logic [DW-1:0] mdr_result, mdr_reminder;

  mdr_cmd_seq #(.DW(DW), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_x         (cmd_x),
    .cmd_y         (cmd_y),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_remainder (rsp_remainder),
    .rsp_error     (rsp_error),
    .rsp_timeout   (rsp_timeout),
    .mdr_start     (mdr_start),
    .mdr_load      (mdr_load),
    .mdr_op        (mdr_op),
    .mdr_data      (mdr_data),
    .mdr_error     (mdr_error),
    .mdr_load_x    (mdr_load_x),
    .mdr_load_y    (mdr_load_y),
    .mdr_ready     (mdr_ready),
    .mdr_result    (mdr_result),
    .mdr_reminder  (mdr_reminder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] res;
    logic [15:0] rem;
    logic        err;
    logic        to;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus monitor
  int          n_start = 0;
  logic [15:0] load_log[$];
  logic [1:0]  start_op[$];
  always @(negedge clk) begin
    if (mdr_start) begin
      n_start++;
      start_op.push_back(mdr_op);
    end
    if (mdr_load) load_log.push_back(mdr_data);
  end

  // MDR model: answers each request one cycle after seeing it
  bit          no_ready  = 1'b0;
  bit          no_load_y = 1'b0;
  logic        req_x, req_y;
  logic [1:0]  m_op;
  logic [15:0] m_a;

  assign mdr_load_x = req_x;
  assign mdr_load_y = req_y && !no_load_y;

  function automatic logic [32:0] mdr_calc(input logic [1:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
    int unsigned ua, ub, p, s;
    ua = a;
    ub = b;
    case (op)
      2'd0: begin
        p = ua * ub;
        return {1'b0, p[15:0], p[31:16]};
      end
      2'd1: begin
        if (ub == 0) return {1'b1, 16'hFFFF, a};
        return {1'b0, 16'(ua / ub), 16'(ua % ub)};
      end
      2'd2: begin
        s = 0;
        while ((s + 1) * (s + 1) <= ua) s++;
        return {1'b0, 16'(s), 16'(ua - s * s)};
      end
      default: return '0;
    endcase
  endfunction

  task automatic model_finish(input logic [32:0] r);
    mdr_result   <= r[31:16];
    mdr_reminder <= r[15:0];
    if (!no_ready) begin
      mdr_ready <= 1'b1;
      mdr_error <= r[32];
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      req_x <= 1'b0; req_y <= 1'b0; m_op <= '0; m_a <= '0;
      mdr_ready <= 1'b0; mdr_error <= 1'b0; mdr_result <= '0; mdr_reminder <= '0;
    end else begin
      mdr_ready <= 1'b0;
      mdr_error <= 1'b0;
      if (mdr_start) begin
        req_x <= 1'b1;
        m_op  <= mdr_op;
      end else if (mdr_load && req_x) begin
        req_x <= 1'b0;
        m_a   <= mdr_data;
        if (m_op == 2'd2) model_finish(mdr_calc(m_op, mdr_data, 16'd0));
        else              req_y <= 1'b1;
      end else if (mdr_load && req_y) begin
        req_y <= 1'b0;
        model_finish(mdr_calc(m_op, m_a, mdr_data));
      end
    end
  end

  task automatic run_cmd(input string name, input logic [1:0] op, input logic [15:0] x,
                         input logic [15:0] y, input logic [15:0] e_res, input logic [15:0] e_rem,
                         input logic e_err, input logic e_to, input int e_lat, input int e_starts,
                         input int e_loads, input logic [15:0] d0, input logic [15:0] d1,
                         input bit hold);
    exp_t e;
    int   s0, l0, hs, n;
    e.res = e_res; e.rem = e_rem; e.err = e_err; e.to = e_to; e.lat = e_lat;
    sb.push_back(e);
    s0 = n_start;
    l0 = load_log.size();
    @(negedge clk);
    cmd_op = op; cmd_x = x; cmd_y = y; cmd_valid = 1'b1;
    if (hold) rsp_ready = 1'b0;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk({name, " cmd_ready"}, cmd_ready, 1);
    @(posedge clk);
    #1;
    hs = cyc;
    cmd_valid = 1'b0;
    @(negedge clk);
    n = 0;
    while (!rsp_valid && n < 400) begin @(negedge clk); n++; end
    chk({name, " rsp_valid"}, rsp_valid, 1);
    e = sb.pop_front();
    chk({name, " latency"}, cyc - hs, e.lat);
    chk({name, " result"}, rsp_result, e.res);
    chk({name, " remainder"}, rsp_remainder, e.rem);
    chk({name, " error"}, rsp_error, e.err);
    chk({name, " timeout"}, rsp_timeout, e.to);
    if (hold) begin
      repeat (10) begin
        @(negedge clk);
        chk({name, " hold"}, {rsp_valid, rsp_timeout, rsp_error, rsp_result, rsp_remainder, cmd_ready},
            {1'b1, e.to, e.err, e.res, e.rem, 1'b0});
      end
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    chk({name, " after rsp"}, {cmd_ready, rsp_valid}, 2'b10);
    chk({name, " starts"}, n_start - s0, e_starts);
    if (start_op.size() > s0) chk({name, " mdr_op"}, start_op[s0], op);
    chk({name, " loads"}, load_log.size() - l0, e_loads);
    if (load_log.size() > l0) chk({name, " data0"}, load_log[l0], d0);
    if (load_log.size() > l0 + 1) chk({name, " data1"}, load_log[l0 + 1], d1);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_x = '0; cmd_y = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset outs", {cmd_ready, rsp_valid, rsp_result, rsp_remainder, rsp_error, rsp_timeout,
                       mdr_start, mdr_load, mdr_op, mdr_data}, {1'b1, 55'd0});
    rst = 1'b0;

    run_cmd("mul", 2'd0, 16'd12, 16'd13, 16'd156, 16'd0, 0, 0, 7, 1, 2, 16'd12, 16'd13, 0);
    run_cmd("div", 2'd1, 16'd172, 16'd5, 16'd34, 16'd2, 0, 0, 7, 1, 2, 16'd172, 16'd5, 0);
    run_cmd("sqrt", 2'd2, 16'd172, 16'hBEEF, 16'd13, 16'd3, 0, 0, 5, 1, 1, 16'd172, 16'd0, 0);
    run_cmd("rsvd", 2'd3, 16'd9, 16'd9, 16'd0, 16'd0, 1, 0, 2, 0, 0, 16'd0, 16'd0, 0);

    no_ready = 1'b1;
    run_cmd("tmo", 2'd0, 16'd3, 16'd4, 16'd0, 16'd0, 0, 1, 5 + TO, 1, 2, 16'd3, 16'd4, 1);
    no_ready = 1'b0;

    run_cmd("div0", 2'd1, 16'd172, 16'd0, 16'hFFFF, 16'd172, 1, 0, 7, 1, 2, 16'd172, 16'd0, 0);

    // Abort while stuck in WAIT_Y
    no_load_y = 1'b1;
    @(negedge clk);
    cmd_op = 2'd1; cmd_x = 16'd172; cmd_y = 16'd5; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("stuck no rsp", rsp_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort outs", {cmd_ready, rsp_valid, rsp_result, rsp_remainder, rsp_error, rsp_timeout,
                       mdr_start, mdr_load, mdr_op, mdr_data}, {1'b1, 55'd0});
    rst = 1'b0;
    no_load_y = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("post abort", {cmd_ready, rsp_valid}, 2'b10);
    end

    run_cmd("mul2", 2'd0, 16'd7, 16'd9, 16'd63, 16'd0, 0, 0, 7, 1, 2, 16'd7, 16'd9, 0);
    chk("sb empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global time limit: total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end

endmodule
